// File: rtl/sumlink_rx.sv
`default_nettype none
// ============================================================================
// Module      : sumlink_rx
// Description : Receive side of the three-neighbour partial-sum link.
//               Each link word is classified as COMMA, DATA or ERROR. A
//               per-link lock FSM declares the link up once it has seen
//               LOCKCNT consecutive valid words that include at least one
//               comma. DATA words that arrive on an up link are passed on.
//               Everything else is replaced by a zero word that carries the
//               comma flag. The words then pass through a per-link
//               programmable delay line so that the three neighbour streams
//               can be brought into alignment.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LOCKCNT : consecutive valid words needed for link-up (2..255)
// Ports
//   clk     in   1  master clock, rising edge
//   reset   in   1  synchronous active-high reset, overrides every input
//   rxdata  in  48  link i word on [16i+:16]
//   rxisk   in   6  link i K flags on [2i+:2], bit 0 = low byte
//   rxerr   in   3  link i decode error for the current word
//   delay   in   9  link i extra alignment delay (0..7) on [3i+:3]
//   errclr  in   1  synchronous clear of all error counters
//   sumdata out 48  aligned partial sums, link i on [16i+:16]
//   xcomma  out  3  1 = comma / no data; the matching sumdata slice is 0
//   linkup  out  3  per-link lock state
//   errcnt  out 48  per-link saturating error counters, link i on [16i+:16]
// ============================================================================
module sumlink_rx #(
  parameter int LOCKCNT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] rxdata,
  input  logic [5:0]  rxisk,
  input  logic [2:0]  rxerr,
  input  logic [8:0]  delay,
  input  logic        errclr,
  output logic [47:0] sumdata,
  output logic [2:0]  xcomma,
  output logic [2:0]  linkup,
  output logic [47:0] errcnt
);

  localparam logic [7:0]  C_LOCKCNT    = 8'(LOCKCNT);
  localparam logic [15:0] C_COMMA_WORD = 16'h00BC;
  localparam logic [1:0]  C_COMMA_ISK  = 2'b01;
  localparam logic [15:0] C_ERRCNT_MAX = 16'hFFFF;
  // Delay-line entry format: {comma_flag, data[15:0]}
  localparam logic [16:0] C_IDLE       = 17'h1_0000;

  localparam logic [0:0]  ST_DOWN      = 1'b0;
  localparam logic [0:0]  ST_UP        = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_link
      logic [15:0] w_word;
      logic [1:0]  w_isk;
      logic        w_err;
      logic        w_is_comma;
      logic        w_is_data;
      logic        w_is_error;

      logic [0:0]  r_state;
      logic [0:0]  w_state_nxt;
      logic [7:0]  r_run;
      logic [7:0]  w_run_nxt;
      logic [7:0]  w_run_inc;
      logic        r_seen;
      logic        w_seen_nxt;
      logic        w_seen_inc;

      logic [16:0] w_s1;
      logic [2:0]  w_tap;
      // r_line[0] is the stage-1 register; r_line[1..7] hold the older words
      logic [16:0] r_line [8];
      logic [16:0] r_out;
      logic [15:0] r_errcnt;

      assign w_word = rxdata[16*gi +: 16];
      assign w_isk  = rxisk[2*gi +: 2];
      assign w_err  = rxerr[gi];
      assign w_tap  = delay[3*gi +: 3];

      // -------------------------------------------------------------------
      // Word classification
      // -------------------------------------------------------------------
      assign w_is_comma = (w_word == C_COMMA_WORD) && (w_isk == C_COMMA_ISK) && !w_err;
      assign w_is_data  = (w_isk == 2'b00) && !w_err;
      assign w_is_error = !(w_is_comma || w_is_data);

      // The run counter saturates at LOCKCNT. A link that has already
      // counted enough words but has not yet seen a comma will lock on the
      // first comma that arrives, because every word of the run is valid.
      assign w_run_inc  = (r_run >= C_LOCKCNT) ? C_LOCKCNT : r_run + 8'd1;
      assign w_seen_inc = r_seen | w_is_comma;

      // -------------------------------------------------------------------
      // Lock FSM: state register
      // -------------------------------------------------------------------
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state <= ST_DOWN;
          r_run   <= 8'd0;
          r_seen  <= 1'b0;
        end else begin
          r_state <= w_state_nxt;
          r_run   <= w_run_nxt;
          r_seen  <= w_seen_nxt;
        end
      end

      // -------------------------------------------------------------------
      // Lock FSM: next-state logic
      // -------------------------------------------------------------------
      always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_seen_nxt  = r_seen;
        case (r_state)
          ST_DOWN: begin
            if (w_is_error) begin
              w_run_nxt  = 8'd0;
              w_seen_nxt = 1'b0;
            end else begin
              w_run_nxt  = w_run_inc;
              w_seen_nxt = w_seen_inc;
              if ((w_run_inc == C_LOCKCNT) && w_seen_inc) begin
                w_state_nxt = ST_UP;
              end
            end
          end
          ST_UP: begin
            if (w_is_error) begin
              w_state_nxt = ST_DOWN;
              w_run_nxt   = 8'd0;
              w_seen_nxt  = 1'b0;
            end
          end
          default: begin
            w_state_nxt = ST_DOWN;
            w_run_nxt   = 8'd0;
            w_seen_nxt  = 1'b0;
          end
        endcase
      end

      // -------------------------------------------------------------------
      // Lock FSM: output logic (stage-1 word)
      // Only DATA on a link that was already up before this word is
      // forwarded, so the word that completes the lock still leaves as a
      // comma.
      // -------------------------------------------------------------------
      always_comb begin
        w_s1 = C_IDLE;
        if (w_is_data && (r_state == ST_UP)) begin
          w_s1 = {1'b0, w_word};
        end
      end

      // -------------------------------------------------------------------
      // Stage 1 + delay line + output register
      // The tap is read every cycle, so a new delay value selects a
      // different entry on the very next edge without disturbing the line.
      // -------------------------------------------------------------------
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < 8; k++) begin
            r_line[k] <= C_IDLE;
          end
          r_out <= C_IDLE;
        end else begin
          r_line[0] <= w_s1;
          for (int k = 1; k < 8; k++) begin
            r_line[k] <= r_line[k-1];
          end
          r_out <= r_line[w_tap];
        end
      end

      // -------------------------------------------------------------------
      // Error counter: clear wins over a same-cycle increment
      // -------------------------------------------------------------------
      always_ff @(posedge clk) begin
        if (reset) begin
          r_errcnt <= 16'd0;
        end else if (errclr) begin
          r_errcnt <= 16'd0;
        end else if (w_is_error && (r_errcnt != C_ERRCNT_MAX)) begin
          r_errcnt <= r_errcnt + 16'd1;
        end
      end

      assign sumdata[16*gi +: 16] = r_out[15:0];
      assign xcomma[gi]           = r_out[16];
      assign linkup[gi]           = (r_state == ST_UP);
      assign errcnt[16*gi +: 16]  = r_errcnt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sumlink_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sumlink_rx
// Description : Self-checking bench for sumlink_rx. A reference model tracks
//               each link's valid-run length and comma history since the last
//               error, keeps a history of the words that each link forwards,
//               and counts errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sumlink_rx;

  localparam int          LOCKCNT = 16;
  localparam logic [16:0] C_IDLE  = 17'h1_0000;
  localparam int          K_COMMA = 0;
  localparam int          K_DATA  = 1;
  localparam int          K_ERR   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] rxdata;
  logic [5:0]  rxisk;
  logic [2:0]  rxerr;
  logic [8:0]  delay;
  logic        errclr;
  logic [47:0] sumdata;
  logic [2:0]  xcomma;
  logic [2:0]  linkup;
  logic [47:0] errcnt;

  int n_pass  = 0;
  int n_total = 0;

  // reference model
  bit          m_up   [3];
  int          m_run  [3];
  bit          m_seen [3];
  int          m_ec   [3];
  logic [16:0] hist   [3][8];
  logic [16:0] m_out  [3];
  logic [8:0]  prev_delay = 9'd0;
  int          settle = 0;
  logic [47:0] exp_sum;
  logic [47:0] exp_ec;
  logic [2:0]  exp_xc;
  logic [2:0]  exp_lu;

  sumlink_rx #(.LOCKCNT(LOCKCNT)) dut (
    .clk     (clk),
    .reset   (reset),
    .rxdata  (rxdata),
    .rxisk   (rxisk),
    .rxerr   (rxerr),
    .delay   (delay),
    .errclr  (errclr),
    .sumdata (sumdata),
    .xcomma  (xcomma),
    .linkup  (linkup),
    .errcnt  (errcnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Put one word of the given kind on link l.
  task automatic drive(input int l, input int kind, input logic [15:0] w);
    int v;
    case (kind)
      K_COMMA: begin
        rxdata[16*l +: 16] = 16'h00BC;
        rxisk[2*l +: 2]    = 2'b01;
        rxerr[l]           = 1'b0;
      end
      K_DATA: begin
        rxdata[16*l +: 16] = w;
        rxisk[2*l +: 2]    = 2'b00;
        rxerr[l]           = 1'b0;
      end
      default: begin
        v = $urandom_range(0, 3);
        rxdata[16*l +: 16] = w;
        rxerr[l]           = 1'b0;
        case (v)
          0: begin rxerr[l] = 1'b1; rxisk[2*l +: 2] = 2'($urandom); end
          1: rxisk[2*l +: 2] = 2'b10;
          2: rxisk[2*l +: 2] = 2'b11;
          default: begin
            rxisk[2*l +: 2]    = 2'b01;
            rxdata[16*l +: 16] = w | 16'h0100;
          end
        endcase
      end
    endcase
  endtask

  task automatic drive_all(input int kind);
    for (int l = 0; l < 3; l++) drive(l, kind, 16'($urandom));
  endtask

  // Advance one clock and update the reference model from the applied inputs.
  task automatic step();
    logic [15:0] w;
    logic [1:0]  k;
    logic        e, isc, isd;
    int          d;
    logic [16:0] s1;
    @(posedge clk);
    if (delay !== prev_delay) settle = 9;
    else if (settle > 0) settle--;
    prev_delay = delay;
    for (int l = 0; l < 3; l++) begin
      if (reset) begin
        m_up[l] = 0; m_run[l] = 0; m_seen[l] = 0; m_ec[l] = 0;
        for (int j = 0; j < 8; j++) hist[l][j] = C_IDLE;
        m_out[l] = C_IDLE;
      end else begin
        w   = rxdata[16*l +: 16];
        k   = rxisk[2*l +: 2];
        e   = rxerr[l];
        isc = (w == 16'h00BC) && (k == 2'b01) && !e;
        isd = (k == 2'b00) && !e;
        d   = int'(delay[3*l +: 3]);
        m_out[l] = hist[l][d];
        s1 = (isd && m_up[l]) ? {1'b0, w} : C_IDLE;
        for (int j = 7; j > 0; j--) hist[l][j] = hist[l][j-1];
        hist[l][0] = s1;
        if (!(isc || isd)) begin
          m_up[l] = 0; m_run[l] = 0; m_seen[l] = 0;
          if (m_ec[l] < 65535) m_ec[l]++;
        end else if (!m_up[l]) begin
          m_run[l]++;
          if (isc) m_seen[l] = 1;
          if (m_run[l] >= LOCKCNT && m_seen[l]) m_up[l] = 1;
        end
        if (errclr) m_ec[l] = 0;
      end
    end
    #1;
    for (int l = 0; l < 3; l++) begin
      exp_sum[16*l +: 16] = m_out[l][15:0];
      exp_xc[l]           = m_out[l][16];
      exp_lu[l]           = m_up[l];
      exp_ec[16*l +: 16]  = 16'(m_ec[l]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; errclr = 1'b0;
    drive_all(K_COMMA);
    step();
    reset = 1'b0;
  endtask

  // One comma followed by LOCKCNT-1 data words on every link.
  task automatic lock_all();
    drive_all(K_COMMA);
    step();
    for (int t = 1; t < LOCKCNT; t++) begin
      drive_all(K_DATA);
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; errclr = 1'b1; delay = 9'h1FF;
    drive_all(K_ERR);
    step();
    step();
    n_total++;
    if (sumdata !== 48'd0) $display("FAIL reset_sumdata: got %h expected 0", sumdata);
    else n_pass++;
    n_total++;
    if (xcomma !== 3'b111) $display("FAIL reset_xcomma: got %b expected 111", xcomma);
    else n_pass++;
    n_total++;
    if (linkup !== 3'b000) $display("FAIL reset_linkup: got %b expected 000", linkup);
    else n_pass++;
    n_total++;
    if (errcnt !== 48'd0) $display("FAIL reset_errcnt: got %h expected 0", errcnt);
    else n_pass++;
    reset = 1'b0; errclr = 1'b0; delay = 9'd0;
  endtask

  task automatic test_lock();
    do_reset();
    delay = 9'd0;
    for (int t = 0; t <= 17; t++) begin
      if (t == 0) drive(0, K_COMMA, 16'h0);
      else if (t < 16) drive(0, K_DATA, 16'h0005);
      else if (t == 16) drive(0, K_DATA, 16'h0123);
      else drive(0, K_DATA, 16'h0777);
      drive(1, K_COMMA, 16'h0); drive(2, K_COMMA, 16'h0);
      step();
      if (t == 14 || t == 15) begin
        n_total++;
        if (linkup[0] !== (t == 15)) $display("FAIL lock_linkup t=%0d: got %b expected %b", t, linkup[0], (t == 15));
        else n_pass++;
      end
      if (t >= 1 && t <= 16) begin
        n_total++;
        if (xcomma[0] !== 1'b1) $display("FAIL lock_comma_out t=%0d: got xcomma %b expected 1", t, xcomma[0]);
        else n_pass++;
      end
      if (t == 17) begin
        n_total++;
        if ({xcomma[0], sumdata[15:0]} !== {1'b0, 16'h0123})
          $display("FAIL lock_first_data: got xc=%b data=%h expected xc=0 data=0123", xcomma[0], sumdata[15:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_no_comma();
    do_reset();
    for (int t = 0; t < 40; t++) begin
      drive_all(K_DATA);
      step();
      n_total++;
      if ({linkup, xcomma, sumdata} !== {3'b000, 3'b111, 48'd0})
        $display("FAIL no_comma t=%0d: got lu=%b xc=%b sum=%h expected lu=000 xc=111 sum=0", t, linkup, xcomma, sumdata);
      else n_pass++;
    end
  endtask

  task automatic test_error_up();
    do_reset();
    lock_all();
    drive_all(K_DATA);
    drive(1, K_ERR, 16'h3C3C);
    step();
    n_total++;
    if ({linkup, errcnt[31:16]} !== {3'b101, 16'd1})
      $display("FAIL err_up_drop: got lu=%b ec1=%h expected lu=101 ec1=0001", linkup, errcnt[31:16]);
    else n_pass++;
    // relock: one comma then 15 data words
    for (int t = 0; t < LOCKCNT; t++) begin
      drive_all(K_DATA);
      if (t == 0) drive(1, K_COMMA, 16'h0);
      step();
      n_total++;
      if ({linkup[1], xcomma[1]} !== {(t == LOCKCNT - 1), 1'b1})
        $display("FAIL err_up_relock t=%0d: got lu1=%b xc1=%b expected lu1=%b xc1=1", t, linkup[1], xcomma[1], (t == LOCKCNT - 1));
      else n_pass++;
    end
  endtask

  task automatic test_delay();
    logic [2:0] hit;
    do_reset();
    lock_all();
    delay = {3'd7, 3'd3, 3'd0};
    for (int t = 0; t < 10; t++) begin
      for (int l = 0; l < 3; l++) drive(l, K_DATA, 16'h1111);
      step();
    end
    n_total++;
    if (linkup !== 3'b111) $display("FAIL delay_locked: got %b expected 111", linkup);
    else n_pass++;
    for (int k = 0; k < 12; k++) begin
      for (int l = 0; l < 3; l++) drive(l, K_DATA, (k == 0) ? 16'hAAAA : 16'h1111);
      step();
      for (int l = 0; l < 3; l++) hit[l] = (sumdata[16*l +: 16] == 16'hAAAA) && !xcomma[l];
      n_total++;
      if (hit !== {(k == 8), (k == 4), (k == 1)})
        $display("FAIL delay_marker k=%0d: got hits %b expected %b", k, hit, {(k == 8), (k == 4), (k == 1)});
      else n_pass++;
    end
    delay = 9'd0;
  endtask

  task automatic test_k_misuse();
    do_reset();
    lock_all();
    drive_all(K_DATA);
    rxdata[15:0] = 16'hBC00; rxisk[1:0] = 2'b10; rxerr[0] = 1'b0;
    step();
    n_total++;
    if ({linkup, errcnt[15:0]} !== {3'b110, 16'd1})
      $display("FAIL k_misuse: got lu=%b ec0=%h expected lu=110 ec0=0001", linkup, errcnt[15:0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    lock_all();
    do_reset();
    n_total++;
    if (linkup !== 3'b000) $display("FAIL mid_reset_drop: got %b expected 000", linkup);
    else n_pass++;
    do_reset();
    drive_all(K_COMMA); step();
    for (int t = 0; t < 10; t++) begin drive_all(K_DATA); step(); end
    do_reset();
    // 6 words after reset: progress from before the reset must not count
    for (int t = 0; t < 6; t++) begin drive_all(K_DATA); step(); end
    n_total++;
    if (linkup !== 3'b000) $display("FAIL mid_reset_progress: got %b expected 000", linkup);
    else n_pass++;
    drive_all(K_COMMA); step();
    for (int t = 0; t < 9; t++) begin drive_all(K_DATA); step(); end
    n_total++;
    if (linkup !== 3'b111) $display("FAIL mid_reset_relock: got %b expected 111", linkup);
    else n_pass++;
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < 3; l++) begin
        r = $urandom_range(0, 99);
        drive(l, (r < 15) ? K_COMMA : (r < 96) ? K_DATA : K_ERR, 16'($urandom));
      end
      if (c % 250 == 100) delay = 9'($urandom);
      errclr = ($urandom_range(0, 99) == 0);
      reset  = ($urandom_range(0, 999) == 0);
      step();
      n_total++;
      if ({linkup, errcnt} !== {exp_lu, exp_ec})
        $display("FAIL rand_state c=%0d: got lu=%b ec=%h expected lu=%b ec=%h", c, linkup, errcnt, exp_lu, exp_ec);
      else n_pass++;
      if (settle == 0) begin
        n_total++;
        if ({xcomma, sumdata} !== {exp_xc, exp_sum})
          $display("FAIL rand_data c=%0d: got xc=%b sum=%h expected xc=%b sum=%h", c, xcomma, sumdata, exp_xc, exp_sum);
        else n_pass++;
      end
    end
    reset = 1'b0; errclr = 1'b0; delay = 9'd0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int t = 0; t < 70000; t++) begin
      drive_all(K_COMMA);
      drive(0, K_ERR, 16'($urandom));
      step();
    end
    n_total++;
    if (errcnt !== {16'd0, 16'd0, 16'hFFFF}) $display("FAIL sat_errcnt: got %h expected 00000000FFFF", errcnt);
    else n_pass++;
    n_total++;
    if (errcnt[15:0] !== exp_ec[15:0]) $display("FAIL sat_model: got %h expected %h", errcnt[15:0], exp_ec[15:0]);
    else n_pass++;
    drive(0, K_ERR, 16'h5555);
    errclr = 1'b1;
    step();
    errclr = 1'b0;
    n_total++;
    if (errcnt[15:0] !== 16'd0) $display("FAIL sat_clear: got %h expected 0000", errcnt[15:0]);
    else n_pass++;
    drive(0, K_ERR, 16'h5555);
    step();
    n_total++;
    if (errcnt[15:0] !== 16'd1) $display("FAIL sat_after_clear: got %h expected 0001", errcnt[15:0]);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; errclr = 1'b0; delay = 9'd0;
    rxdata = 48'd0; rxisk = 6'd0; rxerr = 3'd0;
    test_reset();
    test_lock();
    test_no_comma();
    test_error_up();
    test_delay();
    test_k_misuse();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
